tcm_arbiter: RTL and testbench

Two-port arbiter that shares one single-port tightly coupled SRAM (ITCM or DTCM instance of the general RAM) between the instruction fetch unit and the load/store unit. It sits inside the SRAM wrapper between the core request ports and the general RAM, issues at most one SRAM access per cycle, and returns each response to its owner over a valid/ready channel. Fixed LSU priority is used, with a starvation guard that guarantees IFU progress.

---
 rtl/tcm_arbiter_if.sv | 48 ++++
 rtl/tcm_arbiter.sv | 142 ++++++++++++++
 tb/tb_tcm_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tcm_arbiter_if.sv
// Request, response and SRAM-side signals of the TCM arbiter, bundled so the
// core side (master) and the arbiter (slave) share one connection.
interface tcm_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic                  ifu_req_vld;
  logic                  ifu_req_rdy;
  logic [ADDR_W-1:0]     ifu_req_addr;
  logic                  ifu_rsp_vld;
  logic                  ifu_rsp_rdy;
  logic [DATA_W-1:0]     ifu_rsp_data;

  logic                  lsu_req_vld;
  logic                  lsu_req_rdy;
  logic [ADDR_W-1:0]     lsu_req_addr;
  logic                  lsu_req_we;
  logic [DATA_W-1:0]     lsu_req_wdata;
  logic [DATA_W/8-1:0]   lsu_req_wem;
  logic                  lsu_rsp_vld;
  logic                  lsu_rsp_rdy;
  logic [DATA_W-1:0]     lsu_rsp_data;

  logic                  ram_cs;
  logic                  ram_we;
  logic [ADDR_W-3:0]     ram_addr;
  logic [DATA_W/8-1:0]   ram_wem;
  logic [DATA_W-1:0]     ram_din;
  logic [DATA_W-1:0]     ram_dout;

  modport slave (
    input  ifu_req_vld, ifu_req_addr, ifu_rsp_rdy,
    input  lsu_req_vld, lsu_req_addr, lsu_req_we, lsu_req_wdata, lsu_req_wem, lsu_rsp_rdy,
    input  ram_dout,
    output ifu_req_rdy, ifu_rsp_vld, ifu_rsp_data,
    output lsu_req_rdy, lsu_rsp_vld, lsu_rsp_data,
    output ram_cs, ram_we, ram_addr, ram_wem, ram_din
  );

  modport master (
    output ifu_req_vld, ifu_req_addr, ifu_rsp_rdy,
    output lsu_req_vld, lsu_req_addr, lsu_req_we, lsu_req_wdata, lsu_req_wem, lsu_rsp_rdy,
    output ram_dout,
    input  ifu_req_rdy, ifu_rsp_vld, ifu_rsp_data,
    input  lsu_req_rdy, lsu_rsp_vld, lsu_rsp_data,
    input  ram_cs, ram_we, ram_addr, ram_wem, ram_din
  );
endinterface

// File: rtl/tcm_arbiter.sv
// Shares one single-port TCM between IFU and LSU: fixed LSU priority with a
// starvation guard, one access in flight, one-entry hold buffer for backpressure.
module tcm_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  tcm_arbiter_if.slave   bus
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam int WEM_W = DATA_W / 8;
  localparam int WA_W  = ADDR_W - 2;

  logic              rsp_vld_r;
  logic              rsp_own_r;
  logic              rsp_wr_r;
  logic              hold_vld_r;
  logic [DATA_W-1:0] hold_data_r;
  logic [CNT_W-1:0]  starve_cnt_r;

  logic              owner_rdy_s;
  logic              can_issue_s;
  logic              starve_s;
  logic              lsu_gnt_s;
  logic              ifu_gnt_s;
  logic              lsu_issue_s;
  logic              ifu_issue_s;
  logic              issue_s;
  logic [DATA_W-1:0] rsp_data_s;
  logic              unused_addr_lsb_s;

  assign unused_addr_lsb_s = ^{bus.ifu_req_addr[1:0], bus.lsu_req_addr[1:0]};

  // Arbitration and issue qualification. A stalled response frees the port
  // in the cycle it is accepted, so rsp_vld/owner ready alone gate issue.
  always_comb begin
    owner_rdy_s = rsp_own_r ? bus.lsu_rsp_rdy : bus.ifu_rsp_rdy;
    can_issue_s = rst_n && (!rsp_vld_r || owner_rdy_s);
    starve_s    = (starve_cnt_r == CNT_W'(STARVE_MAX));
    lsu_gnt_s   = bus.lsu_req_vld && !(starve_s && bus.ifu_req_vld);
    ifu_gnt_s   = !lsu_gnt_s && bus.ifu_req_vld;
    lsu_issue_s = can_issue_s && lsu_gnt_s;
    ifu_issue_s = can_issue_s && ifu_gnt_s;
    issue_s     = lsu_issue_s || ifu_issue_s;
  end

  assign bus.lsu_req_rdy = lsu_issue_s;
  assign bus.ifu_req_rdy = ifu_issue_s;

  // SRAM command: driven only on an issue cycle, all-zero otherwise.
  always_comb begin
    bus.ram_cs   = 1'b0;
    bus.ram_we   = 1'b0;
    bus.ram_addr = {WA_W{1'b0}};
    bus.ram_wem  = {WEM_W{1'b0}};
    bus.ram_din  = {DATA_W{1'b0}};
    if (lsu_issue_s) begin
      bus.ram_cs   = 1'b1;
      bus.ram_addr = bus.lsu_req_addr[ADDR_W-1:2];
      if (bus.lsu_req_we) begin
        bus.ram_we  = 1'b1;
        bus.ram_wem = bus.lsu_req_wem;
        bus.ram_din = bus.lsu_req_wdata;
      end else begin
        bus.ram_we  = 1'b0;
      end
    end else if (ifu_issue_s) begin
      bus.ram_cs   = 1'b1;
      bus.ram_addr = bus.ifu_req_addr[ADDR_W-1:2];
    end else begin
      bus.ram_cs   = 1'b0;
    end
  end

  // Response data and per-owner steering.
  always_comb begin
    rsp_data_s       = {DATA_W{1'b0}};
    bus.ifu_rsp_vld  = 1'b0;
    bus.lsu_rsp_vld  = 1'b0;
    bus.ifu_rsp_data = {DATA_W{1'b0}};
    bus.lsu_rsp_data = {DATA_W{1'b0}};
    if (rsp_wr_r) begin
      rsp_data_s = {DATA_W{1'b0}};
    end else if (hold_vld_r) begin
      rsp_data_s = hold_data_r;
    end else begin
      rsp_data_s = bus.ram_dout;
    end
    if (rsp_vld_r && rsp_own_r) begin
      bus.lsu_rsp_vld  = 1'b1;
      bus.lsu_rsp_data = rsp_data_s;
    end else if (rsp_vld_r) begin
      bus.ifu_rsp_vld  = 1'b1;
      bus.ifu_rsp_data = rsp_data_s;
    end else begin
      bus.ifu_rsp_vld  = 1'b0;
    end
  end

  // Response stage, hold buffer and starvation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld_r    <= 1'b0;
      rsp_own_r    <= 1'b0;
      rsp_wr_r     <= 1'b0;
      hold_vld_r   <= 1'b0;
      hold_data_r  <= {DATA_W{1'b0}};
      starve_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (issue_s) begin
        rsp_own_r <= lsu_issue_s;
        rsp_wr_r  <= lsu_issue_s && bus.lsu_req_we;
      end else begin
        rsp_own_r <= rsp_own_r;
        rsp_wr_r  <= rsp_wr_r;
      end

      if (!rsp_vld_r) begin
        rsp_vld_r  <= issue_s;
      end else if (owner_rdy_s) begin
        rsp_vld_r  <= issue_s;
        hold_vld_r <= 1'b0;
      end else if (!hold_vld_r) begin
        // SRAM output is only valid for one cycle; capture it on first stall.
        hold_vld_r  <= 1'b1;
        hold_data_r <= rsp_wr_r ? {DATA_W{1'b0}} : bus.ram_dout;
      end else begin
        hold_vld_r  <= hold_vld_r;
      end

      if (ifu_issue_s || !bus.ifu_req_vld) begin
        starve_cnt_r <= {CNT_W{1'b0}};
      end else if (lsu_issue_s && !starve_s) begin
        starve_cnt_r <= starve_cnt_r + CNT_W'(1);
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end
  end
endmodule

// File: tb/tb_tcm_arbiter.sv
// Randomised and directed bench for tcm_arbiter: a reference model predicts
// grants and responses into a scoreboard that a separate monitor drains.
module tb_tcm_arbiter;
  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
  localparam int WORDS      = 1 << (ADDR_W - 2);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tcm_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  tcm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic        own;   // 1 = LSU
    logic [31:0] data;
    int          cyc;
  } rsp_t;
  rsp_t sb_q[$];

  logic [31:0] ram_mem [WORDS];
  logic [31:0] ref_mem [WORDS];
  bit          ref_init = 1'b0;

  function automatic logic [31:0] init_word(input int i);
    if (i == 32'h20) return 32'h0000_0013;
    if (i == 32'h40) return 32'h1111_1111;
    if (i == 32'h60) return 32'hA5A5_A5A5;
    return (i * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] byte_mask(input logic [3:0] wem);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{wem[b]}};
    return m;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // SRAM model: one-cycle read latency, garbage on the output when idle.
  initial begin
    for (int i = 0; i < WORDS; i++) ram_mem[i] <= init_word(i);
    bus.ram_dout <= 32'h0;
    forever begin
      @(posedge clk);
      cyc <= cyc + 1;
      if (bus.ram_cs) begin
        if (bus.ram_we)
          ram_mem[bus.ram_addr] <= (ram_mem[bus.ram_addr] & ~byte_mask(bus.ram_wem)) |
                                   (bus.ram_din & byte_mask(bus.ram_wem));
        bus.ram_dout <= ram_mem[bus.ram_addr];
      end else begin
        bus.ram_dout <= $urandom;
      end
    end
  end

  // Reference model: predicts ready/grant and SRAM command, pushes responses.
  bit          m_pend = 1'b0;
  bit          m_own = 1'b0;
  int          m_streak = 0;
  bit          a_lsu_g, a_ifu_g, a_can, a_lsu_i, a_ifu_i;
  logic [13:0] a_w;
  logic [31:0] a_mask;
  always @(negedge clk) begin
    if (!ref_init) begin
      for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
      ref_init = 1'b1;
    end
    if (!rst_n) begin
      check("reset_ctl", {bus.ifu_req_rdy, bus.lsu_req_rdy, bus.ifu_rsp_vld, bus.lsu_rsp_vld,
                          bus.ram_cs, bus.ram_we, bus.ram_addr, bus.ram_wem}, 64'h0);
      check("reset_data_a", {bus.ram_din, bus.ifu_rsp_data}, 64'h0);
      check("reset_data_b", {32'h0, bus.lsu_rsp_data}, 64'h0);
      m_pend = 1'b0;
      m_streak = 0;
      sb_q.delete();
    end else begin
      a_lsu_g = bus.lsu_req_vld && !(m_streak == STARVE_MAX && bus.ifu_req_vld);
      a_ifu_g = !a_lsu_g && bus.ifu_req_vld;
      a_can   = !m_pend || (m_own ? bus.lsu_rsp_rdy : bus.ifu_rsp_rdy);
      a_lsu_i = a_can && a_lsu_g;
      a_ifu_i = a_can && a_ifu_g;
      check("req_rdy", {62'h0, bus.ifu_req_rdy, bus.lsu_req_rdy}, {62'h0, a_ifu_i, a_lsu_i});
      if (a_lsu_i) begin
        a_w = bus.lsu_req_addr[15:2];
        if (bus.lsu_req_we) begin
          check("ram_cmd_lsu_wr", {bus.ram_cs, bus.ram_we, bus.ram_addr, bus.ram_wem, bus.ram_din},
                {1'b1, 1'b1, a_w, bus.lsu_req_wem, bus.lsu_req_wdata});
          a_mask = byte_mask(bus.lsu_req_wem);
          ref_mem[a_w] = (ref_mem[a_w] & ~a_mask) | (bus.lsu_req_wdata & a_mask);
          sb_q.push_back('{own: 1'b1, data: 32'h0, cyc: cyc});
        end else begin
          check("ram_cmd_lsu_rd", {bus.ram_cs, bus.ram_we, bus.ram_addr, bus.ram_wem, bus.ram_din},
                {1'b1, 1'b0, a_w, 4'h0, 32'h0});
          sb_q.push_back('{own: 1'b1, data: ref_mem[a_w], cyc: cyc});
        end
      end else if (a_ifu_i) begin
        a_w = bus.ifu_req_addr[15:2];
        check("ram_cmd_ifu", {bus.ram_cs, bus.ram_we, bus.ram_addr, bus.ram_wem, bus.ram_din},
              {1'b1, 1'b0, a_w, 4'h0, 32'h0});
        sb_q.push_back('{own: 1'b0, data: ref_mem[a_w], cyc: cyc});
      end else begin
        check("ram_idle", {bus.ram_cs, bus.ram_we, bus.ram_addr, bus.ram_wem, bus.ram_din}, 64'h0);
      end
      if (!m_pend || (m_own ? bus.lsu_rsp_rdy : bus.ifu_rsp_rdy)) m_pend = a_lsu_i || a_ifu_i;
      if (a_lsu_i || a_ifu_i) m_own = a_lsu_i;
      if (a_ifu_i || !bus.ifu_req_vld) m_streak = 0;
      else if (a_lsu_i && m_streak < STARVE_MAX) m_streak++;
    end
  end

  // Response monitor: the scoreboard head is due one cycle after its issue.
  bit          b_due, b_ei, b_el;
  logic [31:0] b_data;
  always @(negedge clk) begin
    if (rst_n) begin
      b_due  = (sb_q.size() > 0) && (sb_q[0].cyc < cyc);
      b_ei   = b_due && !sb_q[0].own;
      b_el   = b_due && sb_q[0].own;
      b_data = b_due ? sb_q[0].data : 32'h0;
      check("rsp_vld", {62'h0, bus.ifu_rsp_vld, bus.lsu_rsp_vld}, {62'h0, b_ei, b_el});
      check("ifu_rsp_data", {32'h0, bus.ifu_rsp_data}, {32'h0, b_ei ? b_data : 32'h0});
      check("lsu_rsp_data", {32'h0, bus.lsu_rsp_data}, {32'h0, b_el ? b_data : 32'h0});
      if (b_due && (sb_q[0].own ? bus.lsu_rsp_rdy : bus.ifu_rsp_rdy)) void'(sb_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_idle();
    bus.ifu_req_vld   = 1'b0;
    bus.ifu_req_addr  = 16'h0;
    bus.ifu_rsp_rdy   = 1'b1;
    bus.lsu_req_vld   = 1'b0;
    bus.lsu_req_addr  = 16'h0;
    bus.lsu_req_we    = 1'b0;
    bus.lsu_req_wdata = 32'h0;
    bus.lsu_req_wem   = 4'h0;
    bus.lsu_rsp_rdy   = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  bit ifu_fire, lsu_fire;
  initial begin
    drv_idle();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;

    // single IFU read of word 0x20
    bus.ifu_req_vld = 1'b1; bus.ifu_req_addr = 16'h0080;
    step(); drv_idle(); repeat (2) step();

    // partial LSU write, then read back the merged word
    bus.lsu_req_vld = 1'b1; bus.lsu_req_addr = 16'h0100; bus.lsu_req_we = 1'b1;
    bus.lsu_req_wdata = 32'hDEAD_BEEF; bus.lsu_req_wem = 4'b0011;
    step();
    bus.lsu_req_we = 1'b0; bus.lsu_req_wdata = 32'h0; bus.lsu_req_wem = 4'h0;
    step(); drv_idle(); repeat (2) step();

    // contention: both ports valid every cycle
    for (int i = 0; i < 15; i++) begin
      bus.ifu_req_vld = 1'b1; bus.ifu_req_addr = 16'(i * 4);
      bus.lsu_req_vld = 1'b1; bus.lsu_req_addr = 16'(16'h0040 + i * 4);
      step();
    end
    drv_idle(); step();

    // backpressure: IFU response stalled three cycles with both ports requesting
    bus.ifu_req_vld = 1'b1; bus.ifu_req_addr = 16'h0180;
    step();
    bus.ifu_rsp_rdy = 1'b0; bus.ifu_req_addr = 16'h0080;
    bus.lsu_req_vld = 1'b1; bus.lsu_req_addr = 16'h0104;
    repeat (3) step();
    bus.ifu_rsp_rdy = 1'b1;
    step(); drv_idle(); repeat (2) step();

    // streaming: eight sequential IFU reads
    for (int i = 0; i < 8; i++) begin
      bus.ifu_req_vld = 1'b1; bus.ifu_req_addr = 16'(16'h0200 + i * 4);
      step();
    end
    drv_idle(); repeat (2) step();

    // reset while a stalled response is pending, then contention from clean state
    bus.ifu_req_vld = 1'b1; bus.ifu_req_addr = 16'h0080; bus.ifu_rsp_rdy = 1'b0;
    repeat (2) step();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1; bus.ifu_rsp_rdy = 1'b1;
    bus.lsu_req_vld = 1'b1; bus.lsu_req_addr = 16'h0010;
    repeat (10) step();
    drv_idle(); step();

    // randomised traffic; a request is held until it is accepted
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      ifu_fire = bus.ifu_req_vld && bus.ifu_req_rdy;
      lsu_fire = bus.lsu_req_vld && bus.lsu_req_rdy;
      @(posedge clk);
      #1;
      if (!bus.ifu_req_vld || ifu_fire) begin
        bus.ifu_req_vld  = ($urandom_range(0, 3) != 0);
        bus.ifu_req_addr = 16'({$urandom_range(0, 31), 2'($urandom)});
      end
      if (!bus.lsu_req_vld || lsu_fire) begin
        bus.lsu_req_vld   = ($urandom_range(0, 2) != 0);
        bus.lsu_req_addr  = 16'({$urandom_range(0, 31), 2'($urandom)});
        bus.lsu_req_we    = $urandom_range(0, 1) == 1;
        bus.lsu_req_wdata = $urandom;
        bus.lsu_req_wem   = 4'($urandom);
      end
      bus.ifu_rsp_rdy = ($urandom_range(0, 3) != 0);
      bus.lsu_rsp_rdy = ($urandom_range(0, 3) != 0);
    end

    drv_idle();
    repeat (5) step();
    @(negedge clk);
    check("queue_drained", 64'(sb_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
